// File: rtl/exe_mem_pipe_reg_if.sv
// rtl/exe_mem_pipe_reg_if.sv - EXE->MEM handshake and payload bundle for exe_mem_pipe_reg
interface exe_mem_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 16
);
  // EXE side
  logic              inValid;
  logic              inReady;
  logic              writeBackEnIn;
  logic              memReadEnIn;
  logic              memWriteEnIn;
  logic [DATA_W-1:0] resultALUIn;
  logic [DATA_W-1:0] storeValIn;
  logic [DEST_W-1:0] destIn;
  // MEM side
  logic              outValid;
  logic              outReady;
  logic              writeBackEn;
  logic              memReadEn;
  logic              memWriteEn;
  logic [DATA_W-1:0] resultALU;
  logic [DATA_W-1:0] storeVal;
  logic [DEST_W-1:0] dest;
  logic [CNT_W-1:0]  stallCount;

  // Surrounding pipeline: drives the EXE request and the MEM acceptance
  modport master (
    output inValid, writeBackEnIn, memReadEnIn, memWriteEnIn,
    output resultALUIn, storeValIn, destIn, outReady,
    input  inReady, outValid, writeBackEn, memReadEn, memWriteEn,
    input  resultALU, storeVal, dest, stallCount
  );

  // Pipeline register itself
  modport slave (
    input  inValid, writeBackEnIn, memReadEnIn, memWriteEnIn,
    input  resultALUIn, storeValIn, destIn, outReady,
    output inReady, outValid, writeBackEn, memReadEn, memWriteEn,
    output resultALU, storeVal, dest, stallCount
  );
endinterface

// File: rtl/exe_mem_pipe_reg.sv
// rtl/exe_mem_pipe_reg.sv - EXE->MEM pipeline register with flow control, flush and stall counter; EXE_MEM_SKID_EN adds a skid entry
module exe_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  exe_mem_pipe_reg_if.slave  bus
);

  // Payload packs {writeBackEn, memReadEn, memWriteEn, resultALU, storeVal, dest}
  localparam int PL_W = 3 + 2 * DATA_W + DEST_W;

  logic              r_main_valid;
  logic [PL_W-1:0]   r_main_pl;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [PL_W-1:0]   w_in_pl;
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_wb;
  logic              w_mr;
  logic              w_mw;
  logic [DATA_W-1:0] w_res;
  logic [DATA_W-1:0] w_sv;
  logic [DEST_W-1:0] w_dest;

  assign w_in_pl   = {bus.writeBackEnIn, bus.memReadEnIn, bus.memWriteEnIn,
                      bus.resultALUIn, bus.storeValIn, bus.destIn};
  assign w_in_fire = bus.inValid && w_in_ready;

`ifdef EXE_MEM_SKID_EN
  logic            r_skid_valid;
  logic [PL_W-1:0] r_skid_pl;
  logic            w_main_free;

  // Ready is purely registered: only a full skid entry blocks the EXE stage
  assign w_in_ready  = !r_skid_valid;
  // Main entry is empty or being consumed this cycle
  assign w_main_free = !r_main_valid || bus.outReady;

  // Two-deep FIFO: main drives outputs, skid absorbs the instruction that arrives while main stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_pl    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_pl    <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        // Skid is older, so it refills main; inReady was low, so nothing new arrives
        r_main_pl    <= r_skid_pl;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_main_pl    <= w_in_pl;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_pl    <= w_in_pl;
      r_skid_valid <= 1'b1;
    end
  end
`else
  logic w_out_fire;

  // Single entry: accept whenever the slot is empty or drains this cycle
  assign w_in_ready = !r_main_valid || bus.outReady;
  assign w_out_fire = r_main_valid && bus.outReady;

  // Main entry loads on every accepted instruction and empties on a lone consumption
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_pl    <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_main_pl    <= w_in_pl;
      r_main_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_main_valid <= 1'b0;
    end
  end
`endif

  // Saturating count of cycles the MEM stage refuses a valid instruction; flush does not clear it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid && !bus.outReady && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign {w_wb, w_mr, w_mw, w_res, w_sv, w_dest} = r_main_pl;

  // Enables are gated so an empty or squashed slot never touches memory or the register file
  assign bus.inReady     = w_in_ready;
  assign bus.outValid    = r_main_valid;
  assign bus.writeBackEn = w_wb & r_main_valid;
  assign bus.memReadEn   = w_mr & r_main_valid;
  assign bus.memWriteEn  = w_mw & r_main_valid;
  assign bus.resultALU   = w_res;
  assign bus.storeVal    = w_sv;
  assign bus.dest        = w_dest;
  assign bus.stallCount  = r_stall_cnt;

endmodule
